des_sbox_sequencer: RTL and testbench

- Time-multiplexed substitution stage for the DES round function.
- Accepts one 48-bit post-expansion/key-XOR word and walks the eight S-box lookups (s1box..s8box) one per cycle through a single shared 6-bit lookup path.
- Assembles the 32-bit substitution result and returns it with a valid/ready handshake.
- Sits between the key-mix XOR and the P-permutation in the iterative round datapath; a low-area alternative to eight parallel lookups.

---
 rtl/des_sbox_sequencer.sv | 164 ++++++++++++++++
 tb/tb_des_sbox_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_sbox_sequencer.sv
// des_sbox_sequencer
//   Time-multiplexed DES substitution stage. One 48-bit key-mixed word is
//   accepted. Its eight 6-bit chunks then go through a single shared lookup
//   path, one chunk per step, and the eight 4-bit results form a 32-bit word.
//
// Parameters
//   LOOKUP_REG  0: combinational lookup, one step per cycle
//               1: registered lookup, two cycles per step (issue, capture)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_data is valid
//   in_ready   block can accept a word (IDLE)
//   in_data    [1:48] S-box input; bits 1-6 feed S1, ..., bits 43-48 feed S8
//   out_valid  out_data holds a completed result (DONE)
//   out_ready  consumer accepts the result
//   out_data   [1:32] result; bits 1-4 come from S1, ..., bits 29-32 from S8
//   busy       high in RUN or DONE
module des_sbox_sequencer #(
    parameter int LOOKUP_REG = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:48] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:32] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Each S-box is stored as 64 nibbles. Nibble n = row*16 + col, and the
    // leftmost hex digit is nibble 0. Each line below holds one row.
    localparam logic [0:7][255:0] SBOX_TABLE = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // The outer chunk bits (first and sixth) select the row. The inner four
    // bits select the column. Nibble n sits at bits 255-4n down to 252-4n.
    // Because n is 6 bits wide, 255-4n equals {~n, 2'b11}.
    function automatic logic [3:0] sbox_lookup(input logic [255:0] tbl,
                                               input logic [5:0]   chunk);
        logic [5:0] pos;
        pos = {chunk[5], chunk[0], chunk[4:1]};
        return tbl[{~pos, 2'b11} -: 4];
    endfunction

    state_t      state_reg, state_next;
    logic [1:48] word_reg;
    logic [2:0]  idx_reg;
    logic [1:32] data_reg;

    logic [5:0]  chunk_arr [8];
    logic [5:0]  chunk_sel;
    logic [3:0]  sbox_out  [8];
    logic [3:0]  lookup_sel;
    logic [3:0]  nibble_wr;
    logic        step_done;
    logic        accept;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sbox
            assign chunk_arr[gi] = word_reg[6*gi+1 : 6*gi+6];
            assign sbox_out[gi]  = sbox_lookup(SBOX_TABLE[gi], chunk_sel);
        end
    endgenerate

    // Shared path: one chunk is selected, and the matching S-box output is
    // taken from the same index.
    assign chunk_sel  = chunk_arr[idx_reg];
    assign lookup_sel = sbox_out[idx_reg];

    generate
        if (LOOKUP_REG != 0) begin : g_lookup_reg
            logic [3:0] lookup_reg;
            logic       phase_reg;   // 0: issue the lookup, 1: capture the nibble

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lookup_reg <= '0;
                    phase_reg  <= 1'b0;
                end else if (state_reg == RUN) begin
                    phase_reg <= ~phase_reg;
                    if (!phase_reg) begin
                        lookup_reg <= lookup_sel;
                    end
                end else begin
                    phase_reg <= 1'b0;
                end
            end

            assign nibble_wr = lookup_reg;
            assign step_done = (state_reg == RUN) && phase_reg;
        end else begin : g_lookup_comb
            assign nibble_wr = lookup_sel;
            assign step_done = (state_reg == RUN);
        end
    endgenerate

    assign accept    = (state_reg == IDLE) && in_valid;
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_data  = data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = RUN;
            RUN:  if (step_done && idx_reg == 3'd7) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // idx stops at 7 instead of wrapping. Only the next accept resets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg <= '0;
            idx_reg  <= '0;
            data_reg <= '0;
        end else begin
            if (accept) begin
                word_reg <= in_data;
                idx_reg  <= 3'd0;
            end
            if (step_done) begin
                for (int i = 0; i < 8; i++) begin
                    if (idx_reg == 3'(i)) begin
                        data_reg[4*i+1 +: 4] <= nibble_wr;
                    end
                end
                if (idx_reg != 3'd7) begin
                    idx_reg <= idx_reg + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_des_sbox_sequencer.sv
module tb_des_sbox_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_s  [2];
    logic        in_ready_s  [2];
    logic [47:0] in_data_s   [2];
    logic        out_valid_s [2];
    logic        out_ready_s [2];
    logic [31:0] out_data_s  [2];
    logic        busy_s      [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    des_sbox_sequencer #(.LOOKUP_REG(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_data(out_data_s[0]),
        .busy(busy_s[0])
    );

    des_sbox_sequencer #(.LOOKUP_REG(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_data(out_data_s[1]),
        .busy(busy_s[1])
    );

    typedef struct {
        int          d;
        logic [47:0] word;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    // Back-to-back monitor: records the cycle of each input transfer and each result.
    bit          mon_en = 1'b0;
    int          xfer_q [$];
    logic [31:0] res_q  [$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (in_valid_s[0] && in_ready_s[0]) xfer_q.push_back(cyc);
            if (out_valid_s[0] && out_ready_s[0]) res_q.push_back(out_data_s[0]);
        end
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input int d, input string tag);
        check({tag, "_in_ready"},  48'(in_ready_s[d]),  48'd1);
        check({tag, "_out_valid"}, 48'(out_valid_s[d]), 48'd0);
        check({tag, "_out_data"},  48'(out_data_s[d]),  48'd0);
        check({tag, "_busy"},      48'(busy_s[d]),      48'd0);
    endtask

    task automatic run_word(input int d, input logic [47:0] word,
                            input logic [31:0] exp, input int lat);
        int cycles;
        bit seen;
        cycles = 0;
        seen   = 1'b0;
        @(negedge clk);
        check("in_ready_before_word", 48'(in_ready_s[d]), 48'd1);
        in_valid_s[d]  = 1'b1;
        in_data_s[d]   = word;
        out_ready_s[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s[d] = 1'b0;
        in_data_s[d]  = ~word;           // must not affect the latched word
        while (!seen && cycles < 40) begin
            @(posedge clk);
            cycles++;
            #1;
            if (out_valid_s[d]) seen = 1'b1;
        end
        check("out_valid_seen", 48'(seen), 48'd1);
        check("latency", 48'(cycles), 48'(lat));
        check("out_data", 48'(out_data_s[d]), 48'(exp));
        check("busy_in_done", 48'(busy_s[d]), 48'd1);
        $display("dut%0d word %h -> out %h expected %h latency %0d expected %0d",
                 d, word, out_data_s[d], exp, cycles, lat);
        @(posedge clk);
        #1;
        check("out_valid_after_xfer", 48'(out_valid_s[d]), 48'd0);
        check("in_ready_after_xfer", 48'(in_ready_s[d]), 48'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [47:0] bb_w [3];
        logic [31:0] bb_e [3];
        int          cycles;
        bit          seen;

        vecs[0] = '{0, 48'h000000000000, 32'hEFA72C4D, 8};
        vecs[1] = '{0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 8};
        vecs[2] = '{1, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 16};
        vecs[3] = '{1, 48'h000000000000, 32'hEFA72C4D, 16};
        vecs[4] = '{0, 48'hFFFFFF03FFFF, 32'hD9CE2DCB, 8};
        vecs[5] = '{1, 48'hFFFFFF03FFFF, 32'hD9CE2DCB, 16};
        vecs[6] = '{0, 48'h041041041041, 32'h03DDEAD1, 8};
        vecs[7] = '{0, 48'h820820820820, 32'h40DA4917, 8};
        vecs[8] = '{1, 48'h79E79E79E79E, 32'h7A8F9B17, 16};
        vecs[9] = '{1, 48'h041041041041, 32'h03DDEAD1, 16};

        for (int d = 0; d < 2; d++) begin
            in_valid_s[d]  = 1'b0;
            in_data_s[d]   = '0;
            out_ready_s[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values(0, "reset_dut0");
        check_reset_values(1, "reset_dut1");
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            run_word(vecs[v].d, vecs[v].word, vecs[v].exp, vecs[v].lat);
        end

        // Backpressure: the result is held five extra cycles while a new word is offered.
        @(negedge clk);
        out_ready_s[0] = 1'b0;
        in_valid_s[0]  = 1'b1;
        in_data_s[0]   = 48'h000000000000;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        in_data_s[0]  = 48'hFFFFFFFFFFFF;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 40) begin
            @(posedge clk);
            cycles++;
            #1;
            if (out_valid_s[0]) seen = 1'b1;
        end
        check("bp_latency", 48'(cycles), 48'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid_s[0] = 1'b1;
            @(posedge clk);
            #1;
            check("bp_out_valid_held", 48'(out_valid_s[0]), 48'd1);
            check("bp_out_data_stable", 48'(out_data_s[0]), 48'hEFA72C4D);
            check("bp_in_ready_low", 48'(in_ready_s[0]), 48'd0);
        end
        in_valid_s[0]  = 1'b0;
        out_ready_s[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_out_valid_dropped", 48'(out_valid_s[0]), 48'd0);
        check("bp_in_ready_back", 48'(in_ready_s[0]), 48'd1);
        @(posedge clk);
        #1;
        check("bp_ignored_word_not_buffered", 48'(busy_s[0]), 48'd0);
        $display("dut0 backpressure word 000000000000 -> out held %0d extra cycles", 5);

        // Abort mid-RUN: reset during the fourth RUN cycle.
        @(negedge clk);
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 48'hFFFFFFFFFFFF;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", 48'(busy_s[0]), 48'd1);
        rst = 1'b1;
        #1;
        check_reset_values(0, "abort");
        $display("dut0 abort word ffffffffffff during RUN -> outputs reset");
        @(negedge clk);
        rst = 1'b0;
        run_word(0, 48'h000000000000, 32'hEFA72C4D, 8);

        // Back-to-back traffic: in_valid and out_ready held high for three words.
        bb_w[0] = 48'hFFFFFFFFFFFF; bb_e[0] = 32'hD9CE3DCB;
        bb_w[1] = 48'h820820820820; bb_e[1] = 32'h40DA4917;
        bb_w[2] = 48'h000000000000; bb_e[2] = 32'hEFA72C4D;
        @(posedge clk);
        #1;
        xfer_q.delete();
        res_q.delete();
        mon_en         = 1'b1;
        out_ready_s[0] = 1'b1;
        in_valid_s[0]  = 1'b1;
        in_data_s[0]   = bb_w[0];
        for (int c = 0; c < 60 && res_q.size() < 3; c++) begin
            @(posedge clk);
            #1;
            if (xfer_q.size() >= 3) in_valid_s[0] = 1'b0;
            else                    in_data_s[0]  = bb_w[xfer_q.size()];
        end
        mon_en        = 1'b0;
        in_valid_s[0] = 1'b0;
        check("b2b_transfers", 48'(xfer_q.size()), 48'd3);
        check("b2b_results", 48'(res_q.size()), 48'd3);
        for (int k = 0; k < res_q.size() && k < 3; k++) begin
            check("b2b_out_data", 48'(res_q[k]), 48'(bb_e[k]));
            $display("dut0 back-to-back word %h -> out %h expected %h", bb_w[k], res_q[k], bb_e[k]);
        end
        for (int k = 1; k < xfer_q.size() && k < 3; k++) begin
            check("b2b_spacing", 48'(xfer_q[k] - xfer_q[k-1]), 48'd10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
